// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared state encoding and field-width helpers for the read cache
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REFILL_REQ,
    REFILL_DATA,
    RESPOND
  } cache_state_e;

  // ceil(log2(n)); 0 when n <= 1
  function automatic int log2c(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r++;
    end
    return r;
  endfunction

  // width of an index register; never narrower than one bit
  function automatic int idx_bits(input int n);
    return (n > 1) ? log2c(n) : 1;
  endfunction

  // tag width left over once set, word and byte fields are carved out
  function automatic int tag_bits(input int addr_bits, input int capacity,
                                  input int words_per_block, input int ways,
                                  input int word_bits);
    return addr_bits - log2c(capacity / words_per_block / ways)
         - log2c(words_per_block) - log2c(word_bits / 8);
  endfunction

endpackage

// File: rtl/cache_way.sv
// rtl/cache_way.sv - one way of the cache: tag, valid and data storage with compare port
module cache_way
  import cache_pkg::*;
#(
  parameter int SET_COUNT       = 8,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int TAG_BITS        = 25,
  parameter int WORD_BITS       = 32,
  localparam int SET_W          = idx_bits(SET_COUNT),
  localparam int WORD_W         = idx_bits(WORDS_PER_BLOCK)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [SET_W-1:0]     set_idx,
  input  logic [TAG_BITS-1:0]  tag,
  input  logic [WORD_W-1:0]    word_idx,
  output logic                 hit,
  output logic                 valid,
  output logic [WORD_BITS-1:0] rdata,
  input  logic                 wr_en,
  input  logic [WORD_W-1:0]    wr_word,
  input  logic [WORD_BITS-1:0] wdata,
  input  logic                 tag_wr
);

  logic [SET_COUNT-1:0] valid_q;
  logic [TAG_BITS-1:0]  tag_q  [SET_COUNT];
  logic [WORD_BITS-1:0] data_q [SET_COUNT][WORDS_PER_BLOCK];

  // valid bits: cleared by reset or flush, set when the last refill beat lands
  always_ff @(posedge clk) begin
    if (!rst_n || flush) valid_q <= '0;
    else if (tag_wr)     valid_q[set_idx] <= 1'b1;
  end

  // tag and data carry no reset; the valid bit gates every use of them
  always_ff @(posedge clk) begin
    if (tag_wr) tag_q[set_idx] <= tag;
    if (wr_en)  data_q[set_idx][wr_word] <= wdata;
  end

  assign valid = valid_q[set_idx];
  assign hit   = valid && (tag_q[set_idx] == tag);
  assign rdata = data_q[set_idx][word_idx];

endmodule

// File: rtl/set_assoc_read_cache.sv
// rtl/set_assoc_read_cache.sv - N-way set-associative read-only cache with block refill
module set_assoc_read_cache
  import cache_pkg::*;
#(
  parameter int WORD_CAPACITY   = 64,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int WAY_COUNT       = 2,
  parameter int ADDR_BITS       = 32,
  parameter int WORD_BITS       = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [ADDR_BITS-1:0] req_addr_i,
  output logic                 resp_valid_o,
  output logic [WORD_BITS-1:0] resp_data_o,
  output logic                 mem_req_valid_o,
  input  logic                 mem_req_ready_i,
  output logic [ADDR_BITS-1:0] mem_req_addr_o,
  input  logic                 mem_rvalid_i,
  input  logic [WORD_BITS-1:0] mem_rdata_i,
  output logic [31:0]          hit_count_o,
  output logic [31:0]          miss_count_o
);

  localparam int SET_COUNT = WORD_CAPACITY / WORDS_PER_BLOCK / WAY_COUNT;
  localparam int SET_FW    = log2c(SET_COUNT);
  localparam int SET_W     = idx_bits(SET_COUNT);
  localparam int WORD_W    = idx_bits(WORDS_PER_BLOCK);
  localparam int BYTE_OFF  = log2c(WORD_BITS / 8);
  localparam int BLK_OFF   = WORD_W + BYTE_OFF;
  localparam int WAY_W     = idx_bits(WAY_COUNT);
  localparam int TAG_BITS  = tag_bits(ADDR_BITS, WORD_CAPACITY, WORDS_PER_BLOCK,
                                      WAY_COUNT, WORD_BITS);
  localparam logic [ADDR_BITS-1:0] BLK_MASK = {ADDR_BITS{1'b1}} << BLK_OFF;

  cache_state_e         state;
  logic [ADDR_BITS-1:0] addr_q;
  logic [TAG_BITS-1:0]  req_tag;
  logic [SET_W-1:0]     set_idx;
  logic [WORD_W-1:0]    word_idx;
  logic [WORD_W-1:0]    beat_cnt;
  logic [WAY_W-1:0]     victim;
  logic [WAY_W-1:0]     victim_q;
  logic [WAY_W-1:0]     rr_q [SET_COUNT];
  logic [WAY_COUNT-1:0] way_hit;
  logic [WAY_COUNT-1:0] way_valid;
  logic [WAY_COUNT-1:0] way_wr;
  logic [WAY_COUNT-1:0] way_tag_wr;
  logic [WORD_BITS-1:0] way_rdata [WAY_COUNT];
  logic                 hit;
  logic [WORD_BITS-1:0] hit_data;
  logic                 all_valid;
  logic                 flush_now;
  logic                 beat_we;

  assign req_tag  = addr_q[ADDR_BITS-1 -: TAG_BITS];
  assign word_idx = addr_q[BYTE_OFF +: WORD_W];

  if (SET_FW > 0) begin : g_set
    assign set_idx = addr_q[BLK_OFF +: SET_FW];
  end else begin : g_noset
    assign set_idx = '0;
  end

  assign flush_now    = (state == IDLE) && flush_i;
  assign req_ready_o  = (state == IDLE) && !flush_i;
  assign beat_we      = (state == REFILL_DATA) && mem_rvalid_i;
  // after the last beat the refilled line matches, so RESPOND reuses the hit path
  assign resp_valid_o = ((state == LOOKUP) && hit) || (state == RESPOND);
  assign resp_data_o  = resp_valid_o ? hit_data : '0;

  for (genvar w = 0; w < WAY_COUNT; w++) begin : g_way
    assign way_wr[w]     = beat_we && (victim_q == WAY_W'(w));
    assign way_tag_wr[w] = way_wr[w] && (&beat_cnt);

    cache_way #(
      .SET_COUNT      (SET_COUNT),
      .WORDS_PER_BLOCK(WORDS_PER_BLOCK),
      .TAG_BITS       (TAG_BITS),
      .WORD_BITS      (WORD_BITS)
    ) u_way (
      .clk     (clk_i),
      .rst_n   (rst_ni),
      .flush   (flush_now),
      .set_idx (set_idx),
      .tag     (req_tag),
      .word_idx(word_idx),
      .hit     (way_hit[w]),
      .valid   (way_valid[w]),
      .rdata   (way_rdata[w]),
      .wr_en   (way_wr[w]),
      .wr_word (beat_cnt),
      .wdata   (mem_rdata_i),
      .tag_wr  (way_tag_wr[w])
    );
  end

  // merge the per-way compare results; at most one way can match
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int w = 0; w < WAY_COUNT; w++) begin
      if (way_hit[w]) begin
        hit      = 1'b1;
        hit_data = hit_data | way_rdata[w];
      end
    end
  end

  // victim: lowest invalid way, else the set's round-robin pointer
  always_comb begin
    all_valid = &way_valid;
    victim    = rr_q[set_idx];
    for (int w = WAY_COUNT - 1; w >= 0; w--) begin
      if (!way_valid[w]) victim = WAY_W'(w);
    end
  end

  // control FSM with refill request, beat counter, RR pointers and counters
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state           <= IDLE;
      addr_q          <= '0;
      victim_q        <= '0;
      beat_cnt        <= '0;
      mem_req_valid_o <= 1'b0;
      mem_req_addr_o  <= '0;
      hit_count_o     <= '0;
      miss_count_o    <= '0;
      for (int s = 0; s < SET_COUNT; s++) rr_q[s] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!flush_i && req_valid_i) begin
            addr_q <= req_addr_i;
            state  <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (hit_count_o != '1) hit_count_o <= hit_count_o + 32'd1;
            state <= IDLE;
          end else begin
            if (miss_count_o != '1) miss_count_o <= miss_count_o + 32'd1;
            victim_q <= victim;
            // pointer moves only when it actually picked the victim
            if (WAY_COUNT > 1 && all_valid) rr_q[set_idx] <= rr_q[set_idx] + 1'b1;
            mem_req_valid_o <= 1'b1;
            mem_req_addr_o  <= addr_q & BLK_MASK;
            beat_cnt        <= '0;
            state           <= REFILL_REQ;
          end
        end
        REFILL_REQ: begin
          if (mem_req_ready_i) begin
            mem_req_valid_o <= 1'b0;
            state           <= REFILL_DATA;
          end
        end
        REFILL_DATA: begin
          if (mem_rvalid_i) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (&beat_cnt) state <= RESPOND;
          end
        end
        RESPOND: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_set_assoc_read_cache.sv
// tb/tb_set_assoc_read_cache.sv - self-checking bench for set_assoc_read_cache
module tb_set_assoc_read_cache;

  logic        clk = 1'b0;
  logic        rst_n, flush, req_valid, mem_req_ready, mem_rvalid, sel;
  logic [31:0] req_addr, mem_rdata;

  logic        req_valid0, req_valid1, flush0, flush1, mrdy0, mrdy1, mrv0, mrv1;
  logic        req_ready0, req_ready1, resp_valid0, resp_valid1, mreq_valid0, mreq_valid1;
  logic [31:0] resp_data0, resp_data1, mreq_addr0, mreq_addr1, hit0, hit1, miss0, miss1;
  logic        req_ready_s, resp_valid_s, mreq_valid_s;
  logic [31:0] resp_data_s, mreq_addr_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign req_valid0 = req_valid & ~sel;
  assign req_valid1 = req_valid & sel;
  assign flush0     = flush & ~sel;
  assign flush1     = flush & sel;
  assign mrdy0      = mem_req_ready & ~sel;
  assign mrdy1      = mem_req_ready & sel;
  assign mrv0       = mem_rvalid & ~sel;
  assign mrv1       = mem_rvalid & sel;

  assign req_ready_s  = sel ? req_ready1  : req_ready0;
  assign resp_valid_s = sel ? resp_valid1 : resp_valid0;
  assign resp_data_s  = sel ? resp_data1  : resp_data0;
  assign mreq_valid_s = sel ? mreq_valid1 : mreq_valid0;
  assign mreq_addr_s  = sel ? mreq_addr1  : mreq_addr0;

  set_assoc_read_cache dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush0), .req_valid_i(req_valid0),
    .req_ready_o(req_ready0), .req_addr_i(req_addr), .resp_valid_o(resp_valid0),
    .resp_data_o(resp_data0), .mem_req_valid_o(mreq_valid0), .mem_req_ready_i(mrdy0),
    .mem_req_addr_o(mreq_addr0), .mem_rvalid_i(mrv0), .mem_rdata_i(mem_rdata),
    .hit_count_o(hit0), .miss_count_o(miss0)
  );

  set_assoc_read_cache #(.WORD_CAPACITY(32), .WAY_COUNT(1)) dut_dm (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush1), .req_valid_i(req_valid1),
    .req_ready_o(req_ready1), .req_addr_i(req_addr), .resp_valid_o(resp_valid1),
    .resp_data_o(resp_data1), .mem_req_valid_o(mreq_valid1), .mem_req_ready_i(mrdy1),
    .mem_req_addr_o(mreq_addr1), .mem_rvalid_i(mrv1), .mem_rdata_i(mem_rdata),
    .hit_count_o(hit1), .miss_count_o(miss1)
  );

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endfunction

  // backing memory contents: a fixed scramble of the word address
  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // reference model of the default 2-way, 8-set cache
  bit          m_val [8][2];
  logic [31:0] m_tag [8][2];
  int          m_rr  [8];
  int          m_hits, m_misses;

  function automatic void model_flush();
    for (int s = 0; s < 8; s++) for (int w = 0; w < 2; w++) m_val[s][w] = 0;
  endfunction

  function automatic void model_reset();
    model_flush();
    for (int s = 0; s < 8; s++) m_rr[s] = 0;
    m_hits = 0;
    m_misses = 0;
  endfunction

  function automatic bit model_access(logic [31:0] a);
    int s, v;
    logic [31:0] t;
    s = int'((a >> 4) & 32'd7);
    t = a >> 7;
    for (int w = 0; w < 2; w++) begin
      if (m_val[s][w] && m_tag[s][w] == t) begin
        m_hits++;
        return 1;
      end
    end
    m_misses++;
    v = -1;
    for (int w = 0; w < 2; w++) if (!m_val[s][w] && v < 0) v = w;
    if (v < 0) begin
      v = m_rr[s];
      m_rr[s] = (m_rr[s] + 1) % 2;
    end
    m_val[s][v] = 1;
    m_tag[s][v] = t;
    return 0;
  endfunction

  // one read on the selected cache, playing the memory side cycle by cycle;
  // stops early after abort_beats refill beats when abort_beats >= 0
  task automatic do_read(input logic [31:0] addr, input int stall, input int abort_beats,
                         output logic [31:0] data, output int lat, output int nreq,
                         output int vcyc, output logic [31:0] blk, output bit stable,
                         output bit done);
    int stall_left, beats_left, beat_idx;
    logic [31:0] first_addr;
    bit seen;
    stall_left = stall; beats_left = 0; beat_idx = 0; seen = 0; first_addr = '0;
    data = '0; lat = 0; nreq = 0; vcyc = 0; blk = '0; stable = 1; done = 0;
    req_valid = 1'b1;
    req_addr  = addr;
    #1;
    chk("req_ready_idle", req_ready_s, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    for (int c = 1; c <= 100 && !done; c++) begin
      lat = c;
      mem_req_ready = 1'b0;
      mem_rvalid    = 1'b0;
      mem_rdata     = $urandom;
      if (mreq_valid_s) begin
        vcyc++;
        if (!seen) begin seen = 1; first_addr = mreq_addr_s; end
        else if (mreq_addr_s !== first_addr) stable = 0;
      end
      if (beats_left > 0) begin
        if (abort_beats >= 0 && beat_idx == abort_beats) begin
          mem_rvalid = 1'b0;
          return;
        end
        mem_rvalid = 1'b1;
        mem_rdata  = mem_word(blk + 32'(beat_idx * 4));
        beat_idx++;
        beats_left--;
      end else if (mreq_valid_s) begin
        if (stall_left > 0) stall_left--;
        else begin
          mem_req_ready = 1'b1;
          nreq++;
          blk = mreq_addr_s;
          beats_left = 4;
        end
      end
      #1;
      if (resp_valid_s) begin
        data = resp_data_s;
        done = 1;
      end
      @(posedge clk); #1;
    end
    mem_req_ready = 1'b0;
    mem_rvalid    = 1'b0;
  endtask

  // read on the 2-way cache, checked against the reference model
  task automatic check_read(input logic [31:0] addr, input int stall, output bit hit_obs);
    bit exp_hit, stable, done;
    logic [31:0] data, blk;
    int lat, nreq, vcyc;
    exp_hit = model_access(addr);
    do_read(addr, stall, -1, data, lat, nreq, vcyc, blk, stable, done);
    hit_obs = (lat == 1);
    chk("resp_seen", done, 1);
    chk("resp_data", data, mem_word(addr & ~32'h3));
    chk("latency", lat, exp_hit ? 1 : 7 + stall);
    chk("mem_reqs", nreq, exp_hit ? 0 : 1);
    if (!exp_hit) chk("mem_addr", blk, addr & ~32'hF);
  endtask

  typedef struct {
    logic [31:0] addr;
    int          stall;
    bit          exp_hit;
  } vec_t;

  vec_t vt [9];

  initial begin
    bit          h, stable, done;
    logic [31:0] data, blk;
    int          lat, nreq, vcyc;

    vt = '{'{32'h040, 0, 0}, '{32'h044, 0, 1}, '{32'h000, 1, 0},
           '{32'h080, 0, 0}, '{32'h100, 2, 0}, '{32'h080, 0, 1},
           '{32'h000, 0, 0}, '{32'h100, 0, 1}, '{32'h04F, 0, 1}};

    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_addr = '0; sel = 1'b0;
    mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready0, 1);
    chk("rst_resp_valid", resp_valid0, 0);
    chk("rst_resp_data", resp_data0, 0);
    chk("rst_mreq_valid", mreq_valid0, 0);
    chk("rst_mreq_addr", mreq_addr0, 0);
    chk("rst_hits", hit0, 0);
    chk("rst_misses", miss0, 0);
    chk("rst_dm_mreq_valid", mreq_valid1, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      check_read(vt[i].addr, vt[i].stall, h);
      chk($sformatf("vec%0d_hit", i), h, vt[i].exp_hit);
      if (i == 1) begin
        chk("first_pair_hits", hit0, 1);
        chk("first_pair_misses", miss0, 1);
      end
    end
    chk("table_hits", hit0, m_hits);
    chk("table_misses", miss0, m_misses);

    // flush beats a simultaneous request; the held request then misses
    flush = 1'b1; req_valid = 1'b1; req_addr = 32'h44;
    #1;
    chk("flush_req_ready", req_ready0, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    model_flush();
    check_read(32'h44, 0, h);
    chk("after_flush_miss", h, 0);

    // refill request held off for 5 cycles
    void'(model_access(32'h200));
    do_read(32'h200, 5, -1, data, lat, nreq, vcyc, blk, stable, done);
    chk("stall_done", done, 1);
    chk("stall_valid_cycles", vcyc, 6);
    chk("stall_addr_stable", stable, 1);
    chk("stall_single_req", nreq, 1);
    chk("stall_addr", blk, 32'h200);
    chk("stall_latency", lat, 12);
    chk("stall_data", data, mem_word(32'h200));

    // reset after two refill beats
    do_read(32'h300, 0, 2, data, lat, nreq, vcyc, blk, stable, done);
    chk("abort_no_resp", done, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_req_ready", req_ready0, 1);
    chk("mid_rst_resp_valid", resp_valid0, 0);
    chk("mid_rst_resp_data", resp_data0, 0);
    chk("mid_rst_mreq_valid", mreq_valid0, 0);
    chk("mid_rst_mreq_addr", mreq_addr0, 0);
    chk("mid_rst_hits", hit0, 0);
    chk("mid_rst_misses", miss0, 0);
    rst_n = 1'b1;
    model_reset();
    check_read(32'h304, 0, h);
    chk("reread_miss", h, 0);

    // randomized traffic over four tags per set
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        model_flush();
      end
      check_read($urandom_range(0, 511), $urandom_range(0, 2), h);
    end
    chk("rand_hits", hit0, m_hits);
    chk("rand_misses", miss0, m_misses);

    // direct-mapped build: conflicting blocks keep evicting each other
    sel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      blk = (i % 2 == 1) ? 32'h080 : 32'h000;
      do_read(blk, 0, -1, data, lat, nreq, vcyc, blk, stable, done);
      chk($sformatf("dm%0d_latency", i), lat, 7);
      chk($sformatf("dm%0d_data", i), data, mem_word((i % 2 == 1) ? 32'h080 : 32'h000));
    end
    chk("dm_hits", hit1, 0);
    chk("dm_misses", miss1, 4);
    sel = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
